// File: rtl/friscv_dosador.sv
//==============================================================================
// friscv_dosador -- dose sequencer for the Frisc-V juice dispenser: arbitrates
// two juice requests, confirms the cup by measurement, runs one timed pump dose.
// Optional build macro FRISCV_PAUSA_EN: cup loss mid-dose pauses instead of aborting.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module friscv_dosador #(
    parameter int DOSE_CICLOS    = 250000000,
    parameter int MEDIDA_CICLOS  = 5000000,
    parameter int TIMEOUT_CICLOS = 2500000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_liga,
    input  logic       i_pedido_suco_1,
    input  logic       i_pedido_suco_2,
    input  logic       i_copo_posicionado,
    input  logic       i_fim_medida,
    output logic       o_inicia_medida,
    output logic       o_ativa_bomba_1,
    output logic       o_ativa_bomba_2,
    output logic       o_pronto,
    output logic       o_sem_copo,
    output logic       o_erro,
    output logic [3:0] o_db_estado
);

    localparam int c_DOSE_W = $clog2(DOSE_CICLOS + 1);
    localparam int c_MED_W  = $clog2(MEDIDA_CICLOS + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CICLOS + 1);

    localparam logic [c_DOSE_W-1:0] c_DOSE_ULT = c_DOSE_W'(DOSE_CICLOS - 1);
    localparam logic [c_MED_W-1:0]  c_MED_ULT  = c_MED_W'(MEDIDA_CICLOS - 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT_CICLOS);

    typedef enum logic [3:0] {
        S_DESLIGADO = 4'h0,
        S_OCIOSO    = 4'h1,
        S_MEDE      = 4'h2,
        S_ESPERA    = 4'h3,
        S_DOSA      = 4'h4,
        S_PAUSA     = 4'h7,
        S_FIM       = 4'h8,
        S_ERRO      = 4'hE
    } t_estado;

    t_estado             r_estado;
    logic [1:0]          r_pendente;
    logic                r_ultimo;      // juice served last: 0 = juice 1, 1 = juice 2
    logic                r_sel;         // juice in service:  0 = juice 1, 1 = juice 2
    logic                r_aguarda;     // a measurement is outstanding
    logic [c_DOSE_W-1:0] r_dose_cnt;
    logic [c_MED_W-1:0]  r_med_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_inicia;
    logic [1:0]          r_bomba;
    logic                r_pronto;
    logic                r_sem_copo;
    logic                r_erro;

    logic [1:0] w_pend_novo;
    logic [1:0] w_sel_1h;
    logic [1:0] w_pend_limpo;
    logic       w_escolha;
    logic       w_dose_fim;
    logic       w_tick;
    logic       w_timeout;

    assign w_pend_novo  = r_pendente | {i_pedido_suco_2, i_pedido_suco_1};
    assign w_sel_1h     = r_sel ? 2'b10 : 2'b01;
    assign w_pend_limpo = w_pend_novo & ~w_sel_1h;
    // With both juices pending, alternate away from the one served last.
    assign w_escolha    = (&r_pendente) ? ~r_ultimo : r_pendente[1];
    assign w_dose_fim   = (r_dose_cnt == c_DOSE_ULT);
    assign w_tick       = (r_med_cnt == c_MED_ULT);
    assign w_timeout    = r_aguarda && (r_to_cnt == c_TO_MAX) && !i_fim_medida;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado   <= S_DESLIGADO;
            r_pendente <= 2'b00;
            r_ultimo   <= 1'b1;
            r_sel      <= 1'b0;
            r_aguarda  <= 1'b0;
            r_dose_cnt <= '0;
            r_med_cnt  <= '0;
            r_to_cnt   <= '0;
            r_inicia   <= 1'b0;
            r_bomba    <= 2'b00;
            r_pronto   <= 1'b0;
            r_sem_copo <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_inicia   <= 1'b0;
            r_pronto   <= 1'b0;
            r_sem_copo <= 1'b0;
            r_bomba    <= 2'b00;
            r_erro     <= 1'b0;
            if (r_aguarda && r_to_cnt != c_TO_MAX)
                r_to_cnt <= r_to_cnt + 1'b1;
            if (r_estado != S_DESLIGADO)
                r_pendente <= w_pend_novo;

            if (i_liga) begin
                r_aguarda <= 1'b0;
                if (r_estado == S_DESLIGADO) begin
                    r_estado <= S_OCIOSO;
                end else begin
                    r_estado   <= S_DESLIGADO;
                    r_pendente <= 2'b00;
                end
            end else begin
                case (r_estado)
                    S_DESLIGADO: begin
                    end
                    S_OCIOSO: begin
                        if (|r_pendente) begin
                            r_sel     <= w_escolha;
                            r_estado  <= S_MEDE;
                            r_inicia  <= 1'b1;
                            r_aguarda <= 1'b1;
                            r_to_cnt  <= '0;
                        end
                    end
                    S_MEDE: r_estado <= S_ESPERA;
                    S_ESPERA: begin
                        if (i_fim_medida) begin
                            r_aguarda <= 1'b0;
                            if (i_copo_posicionado) begin
                                r_estado   <= S_DOSA;
                                r_bomba    <= w_sel_1h;
                                r_dose_cnt <= '0;
                                r_med_cnt  <= '0;
                            end else begin
                                r_estado   <= S_OCIOSO;
                                r_sem_copo <= 1'b1;
                                r_pendente <= w_pend_limpo;
                            end
                        end else if (w_timeout) begin
                            r_estado  <= S_ERRO;
                            r_erro    <= 1'b1;
                            r_aguarda <= 1'b0;
                        end
                    end
                    S_DOSA: begin
                        if (w_dose_fim) begin
                            r_estado  <= S_FIM;
                            r_pronto  <= 1'b1;
                            r_aguarda <= 1'b0;
                        end else begin
                            r_dose_cnt <= r_dose_cnt + 1'b1;
                            if (i_fim_medida && !i_copo_posicionado) begin
                                r_aguarda <= 1'b0;
`ifdef FRISCV_PAUSA_EN
                                r_estado  <= S_PAUSA;
                                r_med_cnt <= '0;
`else
                                r_estado   <= S_OCIOSO;
                                r_sem_copo <= 1'b1;
                                r_pendente <= w_pend_limpo;
`endif
                            end else if (w_timeout) begin
                                r_estado  <= S_ERRO;
                                r_erro    <= 1'b1;
                                r_aguarda <= 1'b0;
                            end else begin
                                r_bomba <= w_sel_1h;
                                if (i_fim_medida)
                                    r_aguarda <= 1'b0;
                                if (w_tick) begin
                                    r_inicia  <= 1'b1;
                                    r_aguarda <= 1'b1;
                                    r_to_cnt  <= '0;
                                    r_med_cnt <= '0;
                                end else begin
                                    r_med_cnt <= r_med_cnt + 1'b1;
                                end
                            end
                        end
                    end
`ifdef FRISCV_PAUSA_EN
                    S_PAUSA: begin
                        if (i_fim_medida && i_copo_posicionado) begin
                            r_aguarda <= 1'b0;
                            r_estado  <= S_DOSA;
                            r_bomba   <= w_sel_1h;
                            r_med_cnt <= '0;
                        end else if (w_timeout) begin
                            r_estado  <= S_ERRO;
                            r_erro    <= 1'b1;
                            r_aguarda <= 1'b0;
                        end else begin
                            if (i_fim_medida)
                                r_aguarda <= 1'b0;
                            if (w_tick) begin
                                r_inicia  <= 1'b1;
                                r_aguarda <= 1'b1;
                                r_to_cnt  <= '0;
                                r_med_cnt <= '0;
                            end else begin
                                r_med_cnt <= r_med_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    S_FIM: begin
                        r_estado   <= S_OCIOSO;
                        r_pendente <= w_pend_limpo;
                        r_ultimo   <= r_sel;
                    end
                    S_ERRO:  r_erro   <= 1'b1;
                    default: r_estado <= S_DESLIGADO;
                endcase
            end
        end
    end

    assign o_inicia_medida = r_inicia;
    assign o_ativa_bomba_1 = r_bomba[0];
    assign o_ativa_bomba_2 = r_bomba[1];
    assign o_pronto        = r_pronto;
    assign o_sem_copo      = r_sem_copo;
    assign o_erro          = r_erro;
    assign o_db_estado     = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_friscv_dosador.sv
//==============================================================================
// tb_friscv_dosador -- scoreboard bench for friscv_dosador with short timings.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_friscv_dosador;

    localparam int EV_EST    = 0;
    localparam int EV_INI    = 1;
    localparam int EV_PRONTO = 2;
    localparam int EV_SEM    = 3;
    localparam int EV_ERRO   = 4;

    typedef struct {
        int k;
        int v;
    } t_ev;

    logic       clk = 1'b0;
    logic       rst;
    logic       liga, p1, p2, copo, fim;
    logic       ini, b1, b2, pronto, sem, erro;
    logic [3:0] est;

    t_ev q_exp[$];
    int  q_copo[$];
    int  n_checks = 0;
    int  n_err    = 0;

    always #5 clk = ~clk;

    friscv_dosador #(
        .DOSE_CICLOS   (20),
        .MEDIDA_CICLOS (5),
        .TIMEOUT_CICLOS(8)
    ) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_liga            (liga),
        .i_pedido_suco_1   (p1),
        .i_pedido_suco_2   (p2),
        .i_copo_posicionado(copo),
        .i_fim_medida      (fim),
        .o_inicia_medida   (ini),
        .o_ativa_bomba_1   (b1),
        .o_ativa_bomba_2   (b2),
        .o_pronto          (pronto),
        .o_sem_copo        (sem),
        .o_erro            (erro),
        .o_db_estado       (est)
    );

    task automatic esperado(input int k, input int v);
        t_ev e;
        e.k = k;
        e.v = v;
        q_exp.push_back(e);
    endtask

    task automatic exp_meas();
        esperado(EV_EST, 2);
        esperado(EV_INI, 0);
        esperado(EV_EST, 3);
    endtask

    task automatic exp_dose(input int j);
        esperado(EV_EST, 4);
        esperado(EV_INI, 6);
        esperado(EV_INI, 11);
        esperado(EV_INI, 16);
        esperado(EV_EST, 8);
        esperado(EV_PRONTO, j * 1000 + 20);
        esperado(EV_EST, 1);
    endtask

    task automatic confere(input int k, input int v, input string nome);
        t_ev e;
        n_checks++;
        if (q_exp.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event, value %0d, nothing required", nome, v);
        end else begin
            e = q_exp.pop_front();
            if (e.k != k || e.v != v) begin
                n_err++;
                $display("FAIL %s: got kind %0d value %0d, required kind %0d value %0d",
                         nome, k, v, e.k, e.v);
            end
        end
    endtask

    task automatic chk(input string nome, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nome, got, req);
        end
    endtask

    task automatic pulsa(input logic l, input logic a, input logic b);
        @(negedge clk);
        liga = l; p1 = a; p2 = b;
        @(negedge clk);
        liga = 1'b0; p1 = 1'b0; p2 = 1'b0;
    endtask

    task automatic wait_est(input int v, input int max);
        int n = 0;
        while (int'(est) != v && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_estado", int'(est), v);
    endtask

    // Scoreboard monitor: every DUT-visible event pops one expectation.
    initial begin : monitor
        int   total = 0;
        int   ult   = 0;
        logic prev_erro = 1'b0;
        logic [3:0] prev_est = 4'h0;
        forever begin
            @(negedge clk);
            if (est != prev_est) begin
                confere(EV_EST, int'(est), "estado");
                prev_est = est;
                if (est == 4'h0) total = 0;
            end
            if (b1 || b2) total++;
            if (b1) ult = 1;
            if (b2) ult = 2;
            chk("bombas_exclusivas", int'(b1 && b2), 0);
            if (ini) confere(EV_INI, total, "inicia_medida");
            if (pronto) begin
                confere(EV_PRONTO, ult * 1000 + total, "pronto");
                total = 0;
            end
            if (sem) begin
                confere(EV_SEM, total, "sem_copo");
                total = 0;
            end
            if (erro && !prev_erro) confere(EV_ERRO, int'({b2, b1}), "erro");
            prev_erro = erro;
        end
    end

    // Sensor model: answers each measurement one cycle later from q_copo.
    initial begin : sensor
        int c;
        fim = 1'b0;
        copo = 1'b0;
        forever begin
            @(negedge clk);
            if (ini && q_copo.size() > 0) begin
                c = q_copo.pop_front();
                @(negedge clk);
                fim = 1'b1;
                copo = (c != 0);
                @(negedge clk);
                fim = 1'b0;
                copo = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        rst = 1'b1; liga = 1'b0; p1 = 1'b0; p2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({ini, b1, b2, pronto, sem, erro, est}), 0);
        rst = 1'b0;

        // Single uninterrupted dose of juice 1
        esperado(EV_EST, 1);
        pulsa(1'b1, 1'b0, 1'b0);
        exp_meas();
        exp_dose(1);
        for (int i = 0; i < 4; i++) q_copo.push_back(1);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(8, 100);
        wait_est(1, 5);

        // Reset so arbitration restarts with juice 1
        esperado(EV_EST, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        esperado(EV_EST, 1);
        pulsa(1'b1, 1'b0, 1'b0);

        // Both requests in the same cycle: juice 1 then juice 2
        exp_meas();
        exp_dose(1);
        exp_meas();
        exp_dose(2);
        for (int i = 0; i < 8; i++) q_copo.push_back(1);
        pulsa(1'b0, 1'b1, 1'b1);
        wait_est(8, 100);
        wait_est(1, 5);
        wait_est(8, 100);
        wait_est(1, 5);

        // No cup at the initial measurement
        exp_meas();
        esperado(EV_EST, 1);
        esperado(EV_SEM, 0);
        q_copo.push_back(0);
        pulsa(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("inicia_2_ciclos", int'(ini), 1);
        wait_est(3, 10);
        wait_est(1, 10);

        // Cup lost at the second in-dose measurement
        exp_meas();
        esperado(EV_EST, 4);
        esperado(EV_INI, 6);
        esperado(EV_INI, 11);
`ifdef FRISCV_PAUSA_EN
        esperado(EV_EST, 7);
        esperado(EV_INI, 12);
        esperado(EV_EST, 4);
        esperado(EV_INI, 18);
        esperado(EV_EST, 8);
        esperado(EV_PRONTO, 1020);
        esperado(EV_EST, 1);
        q_copo.push_back(1); q_copo.push_back(1); q_copo.push_back(0);
        q_copo.push_back(1); q_copo.push_back(1);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(7, 40);
        wait_est(8, 60);
        wait_est(1, 5);
`else
        esperado(EV_EST, 1);
        esperado(EV_SEM, 12);
        q_copo.push_back(1); q_copo.push_back(1); q_copo.push_back(0);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(4, 20);
        wait_est(1, 40);
`endif

        // Sensor silent: timeout to ERRO, then off/on and a fresh request
        exp_meas();
        esperado(EV_EST, 14);
        esperado(EV_ERRO, 0);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(14, 30);
        repeat (3) @(negedge clk);
        chk("erro_nivel", int'(erro), 1);
        esperado(EV_EST, 0);
        pulsa(1'b1, 1'b0, 1'b0);
        esperado(EV_EST, 1);
        pulsa(1'b1, 1'b0, 1'b0);
        exp_meas();
        exp_dose(1);
        for (int i = 0; i < 4; i++) q_copo.push_back(1);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(8, 100);
        wait_est(1, 5);

        // Asynchronous reset in the middle of a dose
        exp_meas();
        esperado(EV_EST, 4);
        esperado(EV_INI, 6);
        esperado(EV_EST, 0);
        q_copo.push_back(1); q_copo.push_back(1);
        pulsa(1'b0, 1'b1, 1'b0);
        wait_est(4, 20);
        repeat (8) @(negedge clk);
        chk("bomba_antes_reset", int'(b1), 1);
        #3 rst = 1'b1;
        #1 chk("reset_imediato", int'({ini, b1, b2, pronto, sem, erro, est}), 0);
        @(negedge clk);
        rst = 1'b0;
        q_copo.delete();
        repeat (4) @(negedge clk);

        chk("fila_vazia", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
